imm_operand_encoder: RTL

- Multi-cycle inverse of the execution-stage Val2 operand decoder.
- Takes a 32-bit constant and searches for the 12-bit shifter-operand encoding {rotate_imm[3:0], immed_8[7:0]}. The decode side then reproduces the constant as immed_8 rotated right by 2*rotate_imm.
- In memory mode, checks the constant against a zero-extended 12-bit offset instead.
- Used by the instruction-generation/test-stimulus path and the constant-folding helper next to the execution stage.

---
 rtl/imm_operand_encoder.sv | 107 ++++++++++
 1 files changed

// File: rtl/imm_operand_encoder.sv
// Iterative search for the 12-bit {rotate_imm, immed_8} encoding of a 32-bit constant, or a 12-bit memory-offset fit check.
// Latency 2..MAX_ROT+2 cycles from accept to a one-cycle done; start is ignored while busy (no queuing).
module imm_operand_encoder #(
    parameter int MAX_ROT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        is_mem,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] shift_operand
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] ROT_LAST = 4'(MAX_ROT);

    state_t      state;
    logic [3:0]  rot;
    logic [31:0] cap_value;
    logic        cap_mem;

    logic [4:0]  shamt;
    logic [63:0] rot_pair;
    logic [31:0] cand;
    logic        hit;
    logic        last_rot;
    logic        mem_fit;

    // Rotating left by 2*rot undoes the decoder's rotate right; the doubled
    // word keeps wrap-around bits and makes a zero shift an identity.
    always_comb begin
        shamt    = {rot, 1'b0};
        rot_pair = {cap_value, cap_value} << shamt;
        cand     = rot_pair[63:32];
        hit      = (cand[31:8] == 24'd0);
        last_rot = (rot == ROT_LAST);
        mem_fit  = (cap_value[31:12] == 20'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rot           <= 4'd0;
            cap_value     <= 32'd0;
            cap_mem       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            shift_operand <= 12'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cap_value     <= value;
                        cap_mem       <= is_mem;
                        rot           <= 4'd0;
                        valid         <= 1'b0;
                        shift_operand <= 12'd0;
                        busy          <= 1'b1;
                        state         <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (cap_mem) begin
                        valid         <= mem_fit;
                        shift_operand <= mem_fit ? cap_value[11:0] : 12'd0;
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end else if (hit) begin
                        // First hit is the smallest rotation: canonical encoding.
                        valid         <= 1'b1;
                        shift_operand <= {rot, cand[7:0]};
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end else if (last_rot) begin
                        valid         <= 1'b0;
                        shift_operand <= 12'd0;
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        rot <= rot + 4'd1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
